rf_op_sequencer: RTL and testbench

//  Initiator side of the 8x16 register-file port set (AAddress/BAddress read, DAddress/DData/ReadOrWrite write).

---
 rtl/rf_seq_pkg.sv | 32 +++
 rtl/rf_op_sequencer_if.sv | 34 +++
 rtl/rf_seq_alu.sv | 61 ++++++
 rtl/rf_op_sequencer.sv | 113 +++++++++++
 tb/tb_rf_op_sequencer.sv | 155 +++++++++++++++
 5 files changed

// File: rtl/rf_seq_pkg.sv
// Shared definitions for the register-file micro-op sequencer: opcodes, FSM states, flag positions.
package rf_seq_pkg;

    localparam logic [3:0] OP_MOVA = 4'h0;
    localparam logic [3:0] OP_INC  = 4'h1;
    localparam logic [3:0] OP_ADD  = 4'h2;
    localparam logic [3:0] OP_SUB  = 4'h3;
    localparam logic [3:0] OP_DEC  = 4'h4;
    localparam logic [3:0] OP_AND  = 4'h5;
    localparam logic [3:0] OP_OR   = 4'h6;
    localparam logic [3:0] OP_XOR  = 4'h7;
    localparam logic [3:0] OP_NOT  = 4'h8;
    localparam logic [3:0] OP_MOVB = 4'h9;
    localparam logic [3:0] OP_SHR  = 4'hA;
    localparam logic [3:0] OP_SHL  = 4'hB;
    localparam logic [3:0] OP_LDI  = 4'hC;
    localparam logic [3:0] OP_ADDI = 4'hD;
    localparam logic [3:0] OP_NOP  = 4'hE;

    localparam int unsigned FLAG_Z = 0;
    localparam int unsigned FLAG_N = 1;
    localparam int unsigned FLAG_C = 2;
    localparam int unsigned FLAG_V = 3;

    typedef enum logic [1:0] {StIdle, StRead, StExec, StWrite} state_e;

    // Both 0xE and 0xF decode as NOP.
    function automatic logic is_nop(input logic [3:0] op);
        return op[3:1] == 3'b111;
    endfunction

endpackage

// File: rtl/rf_op_sequencer_if.sv
// Micro-op input handshake plus register-file read/write ports of the sequencer.
interface rf_op_sequencer_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 3
);
    logic              InValid;
    logic              InReady;
    logic [3:0]        InOp;
    logic              InWrite;
    logic [ADDR_W-1:0] InDA;
    logic [ADDR_W-1:0] InAA;
    logic [ADDR_W-1:0] InBA;
    logic [DATA_W-1:0] InConst;
    logic [ADDR_W-1:0] AAddress;
    logic [ADDR_W-1:0] BAddress;
    logic [DATA_W-1:0] AData;
    logic [DATA_W-1:0] BData;
    logic [ADDR_W-1:0] DAddress;
    logic [DATA_W-1:0] DData;
    logic              ReadOrWrite;
    logic              Busy;
    logic              Done;
    logic [3:0]        Flags;

    modport master (
        input  InValid, InOp, InWrite, InDA, InAA, InBA, InConst, AData, BData,
        output InReady, AAddress, BAddress, DAddress, DData, ReadOrWrite, Busy, Done, Flags
    );

    modport slave (
        output InValid, InOp, InWrite, InDA, InAA, InBA, InConst, AData, BData,
        input  InReady, AAddress, BAddress, DAddress, DData, ReadOrWrite, Busy, Done, Flags
    );
endinterface

// File: rtl/rf_seq_alu.sv
// Combinational function unit: result and {V,C,N,Z} flags from registered operands.
module rf_seq_alu
    import rf_seq_pkg::*;
#(
    parameter int unsigned DATA_W = 16
) (
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic [DATA_W-1:0] const_i,
    input  logic [3:0]        op_i,
    output logic [DATA_W-1:0] r_o,
    output logic [3:0]        flags_o
);
    localparam int unsigned Msb = DATA_W - 1;

    logic              arith;
    logic              cin;
    logic [DATA_W-1:0] y;
    logic [DATA_W:0]   sum;
    logic              c;
    logic              v;

    always_comb begin
        arith = 1'b0;
        cin   = 1'b0;
        y     = '0;
        sum   = '0;
        r_o   = '0;
        c     = 1'b0;
        v     = 1'b0;
        case (op_i)
            OP_MOVA: r_o = a_i;
            OP_INC:  begin arith = 1'b1; cin = 1'b1; end
            OP_ADD:  begin arith = 1'b1; y = b_i; end
            OP_SUB:  begin arith = 1'b1; y = ~b_i; cin = 1'b1; end
            OP_DEC:  begin arith = 1'b1; y = '1; end
            OP_AND:  r_o = a_i & b_i;
            OP_OR:   r_o = a_i | b_i;
            OP_XOR:  r_o = a_i ^ b_i;
            OP_NOT:  r_o = ~a_i;
            OP_MOVB: r_o = b_i;
            OP_SHR:  begin r_o = b_i >> 1; c = b_i[0]; end
            OP_SHL:  begin r_o = b_i << 1; c = b_i[Msb]; end
            OP_LDI:  r_o = const_i;
            OP_ADDI: begin arith = 1'b1; y = const_i; end
            default: r_o = '0;
        endcase
        // Every arithmetic op is a + y + cin, so carry and overflow share one adder.
        if (arith) begin
            sum = {1'b0, a_i} + {1'b0, y} + {{DATA_W{1'b0}}, cin};
            r_o = sum[DATA_W-1:0];
            c   = sum[DATA_W];
            v   = (a_i[Msb] == y[Msb]) && (r_o[Msb] != a_i[Msb]);
        end
        flags_o         = '0;
        flags_o[FLAG_V] = v;
        flags_o[FLAG_C] = c;
        flags_o[FLAG_N] = r_o[Msb];
        flags_o[FLAG_Z] = (r_o == '0);
    end
endmodule

// File: rtl/rf_op_sequencer.sv
// Accepts one micro-op per handshake, reads two registers, executes and writes back.
module rf_op_sequencer
    import rf_seq_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 3
) (
    input logic                clk,
    input logic                rst_n,
    rf_op_sequencer_if.master  bus
);
    state_e            state_q;
    logic [3:0]        op_q;
    logic              write_q;
    logic [ADDR_W-1:0] da_q;
    logic [DATA_W-1:0] const_q;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic [ADDR_W-1:0] aaddr_q;
    logic [ADDR_W-1:0] baddr_q;
    logic [ADDR_W-1:0] daddr_q;
    logic [DATA_W-1:0] ddata_q;
    logic              row_q;
    logic              done_q;
    logic              busy_q;
    logic              ready_q;
    logic [3:0]        flags_q;
    logic [DATA_W-1:0] alu_r;
    logic [3:0]        alu_flags;

    rf_seq_alu #(.DATA_W(DATA_W)) u_alu (
        .a_i     (a_q),
        .b_i     (b_q),
        .const_i (const_q),
        .op_i    (op_q),
        .r_o     (alu_r),
        .flags_o (alu_flags)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            op_q    <= '0;
            write_q <= 1'b0;
            da_q    <= '0;
            const_q <= '0;
            a_q     <= '0;
            b_q     <= '0;
            aaddr_q <= '0;
            baddr_q <= '0;
            daddr_q <= '0;
            ddata_q <= '0;
            row_q   <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
            flags_q <= '0;
        end else begin
            row_q  <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (bus.InValid) begin
                        op_q    <= bus.InOp;
                        write_q <= bus.InWrite;
                        da_q    <= bus.InDA;
                        const_q <= bus.InConst;
                        aaddr_q <= bus.InAA;
                        baddr_q <= bus.InBA;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= StRead;
                    end
                end
                StRead: begin
                    a_q     <= bus.AData;
                    b_q     <= bus.BData;
                    state_q <= StExec;
                end
                StExec: begin
                    done_q <= 1'b1;
                    if (!is_nop(op_q)) flags_q <= alu_flags;
                    if (write_q && !is_nop(op_q)) begin
                        daddr_q <= da_q;
                        ddata_q <= alu_r;
                        row_q   <= 1'b1;
                        state_q <= StWrite;
                    end else begin
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                StWrite: begin
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.InReady     = ready_q;
    assign bus.AAddress    = aaddr_q;
    assign bus.BAddress    = baddr_q;
    assign bus.DAddress    = daddr_q;
    assign bus.DData       = ddata_q;
    assign bus.ReadOrWrite = row_q;
    assign bus.Busy        = busy_q;
    assign bus.Done        = done_q;
    assign bus.Flags       = flags_q;
endmodule

// File: tb/tb_rf_op_sequencer.sv
// Directed bench for rf_op_sequencer with a behavioural 8x16 register file.
module tb_rf_op_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    rf_op_sequencer_if #(.DATA_W(16), .ADDR_W(3)) bus ();

    rf_op_sequencer #(.DATA_W(16), .ADDR_W(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [15:0] rf [8] = '{default: 16'h0000};
    assign bus.AData = rf[bus.AAddress];
    assign bus.BData = rf[bus.BAddress];
    always @(posedge clk) if (bus.ReadOrWrite) rf[bus.DAddress] <= bus.DData;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [3:0] op, input logic wr, input logic [2:0] da,
                         input logic [2:0] aa, input logic [2:0] ba, input logic [15:0] cst);
        bus.InValid = v;
        bus.InOp    = op;
        bus.InWrite = wr;
        bus.InDA    = da;
        bus.InAA    = aa;
        bus.InBA    = ba;
        bus.InConst = cst;
    endtask

    // Issues one op and checks the t+3 result cycle.
    task automatic do_op(input string tag, input logic [3:0] op, input logic wr,
                         input logic [2:0] da, input logic [2:0] aa, input logic [2:0] ba,
                         input logic [15:0] cst, input logic exp_we, input logic [15:0] exp_d,
                         input logic [3:0] exp_f);
        int n = 0;
        @(negedge clk);
        while (!bus.InReady && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_eq({tag, ".ready"}, bus.InReady, 1);
        drive(1'b1, op, wr, da, aa, ba, cst);
        @(posedge clk);
        #1 bus.InValid = 1'b0;
        @(negedge clk);
        check_eq({tag, ".busy"}, bus.Busy, 1);
        check_eq({tag, ".aaddr"}, bus.AAddress, aa);
        check_eq({tag, ".baddr"}, bus.BAddress, ba);
        @(negedge clk);
        check_eq({tag, ".we_early"}, {bus.ReadOrWrite, bus.Done}, 0);
        @(negedge clk);
        check_eq({tag, ".done"}, bus.Done, 1);
        check_eq({tag, ".we"}, bus.ReadOrWrite, exp_we);
        check_eq({tag, ".flags"}, bus.Flags, exp_f);
        if (exp_we) begin
            check_eq({tag, ".daddr"}, bus.DAddress, da);
            check_eq({tag, ".ddata"}, bus.DData, exp_d);
            @(negedge clk);
            check_eq({tag, ".done_clr"}, {bus.ReadOrWrite, bus.Done}, 0);
        end
    endtask

    initial begin
        int acc;
        int wr;
        logic [15:0] exp_w [3];
        exp_w[0] = 16'h000A;
        exp_w[1] = 16'h0014;
        exp_w[2] = 16'h0028;
        drive(1'b0, 4'h0, 1'b0, 3'd0, 3'd0, 3'd0, 16'h0);
        #12;
        check_eq("rst.ready", bus.InReady, 1);
        check_eq("rst.ctl", {bus.ReadOrWrite, bus.Done, bus.Busy}, 0);
        check_eq("rst.flags", bus.Flags, 0);
        check_eq("rst.addr", {bus.AAddress, bus.BAddress, bus.DAddress}, 0);
        check_eq("rst.ddata", bus.DData, 0);
        @(negedge clk);
        rst_n = 1'b1;

        do_op("ldi1", 4'hC, 1'b1, 3'd1, 3'd0, 3'd0, 16'h7FFF, 1'b1, 16'h7FFF, 4'b0000);
        do_op("ldi2", 4'hC, 1'b1, 3'd2, 3'd0, 3'd0, 16'h0001, 1'b1, 16'h0001, 4'b0000);
        do_op("add", 4'h2, 1'b1, 3'd3, 3'd1, 3'd2, 16'h0, 1'b1, 16'h8000, 4'b1010);
        check_eq("rf3", rf[3], 16'h8000);
        do_op("sub", 4'h3, 1'b1, 3'd4, 3'd2, 3'd2, 16'h0, 1'b1, 16'h0000, 4'b0101);
        do_op("dec", 4'h4, 1'b1, 3'd5, 3'd0, 3'd0, 16'h0, 1'b1, 16'hFFFF, 4'b0010);
        do_op("ldi3", 4'hC, 1'b1, 3'd6, 3'd0, 3'd0, 16'h0003, 1'b1, 16'h0003, 4'b0000);
        do_op("shr", 4'hA, 1'b1, 3'd7, 3'd0, 3'd6, 16'h0, 1'b1, 16'h0001, 4'b0100);
        do_op("ldi8001", 4'hC, 1'b1, 3'd6, 3'd0, 3'd0, 16'h8001, 1'b1, 16'h8001, 4'b0010);
        do_op("shl", 4'hB, 1'b1, 3'd7, 3'd0, 3'd6, 16'h0, 1'b1, 16'h0002, 4'b0100);
        check_eq("rf7", rf[7], 16'h0002);
        do_op("add_nw", 4'h2, 1'b0, 3'd3, 3'd1, 3'd2, 16'h0, 1'b0, 16'h0, 4'b1010);
        do_op("nop", 4'hE, 1'b1, 3'd3, 3'd0, 3'd0, 16'h0, 1'b0, 16'h0, 4'b1010);
        check_eq("rf3_kept", rf[3], 16'h8000);
        do_op("ldi5", 4'hC, 1'b1, 3'd1, 3'd0, 3'd0, 16'h0005, 1'b1, 16'h0005, 4'b0000);

        // InValid held high: accepts at offsets 0,4,8, writes at 3,7,11.
        @(negedge clk);
        acc = 0;
        wr = 0;
        drive(1'b1, 4'h2, 1'b1, 3'd1, 3'd1, 3'd1, 16'h0);
        for (int i = 0; i < 12; i++) begin
            if (bus.InReady) begin
                check_eq("b2b.acc_cyc", i, acc * 4);
                acc++;
            end
            if (bus.ReadOrWrite && wr < 3) begin
                check_eq("b2b.wr_cyc", i, wr * 4 + 3);
                check_eq("b2b.wr_data", bus.DData, exp_w[wr]);
                wr++;
            end
            if (i == 11) bus.InValid = 1'b0;
            @(negedge clk);
        end
        check_eq("b2b.acc_cnt", acc, 3);
        check_eq("b2b.wr_cnt", wr, 3);

        // Abort in WRITE: r5 must keep its value.
        drive(1'b1, 4'hC, 1'b1, 3'd5, 3'd0, 3'd0, 16'h1234);
        @(posedge clk);
        #1 bus.InValid = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("abort.we_pre", bus.ReadOrWrite, 1);
        rst_n = 1'b0;
        #1;
        check_eq("abort.we", bus.ReadOrWrite, 0);
        check_eq("abort.ready", bus.InReady, 1);
        check_eq("abort.flags", bus.Flags, 0);
        check_eq("abort.done", {bus.Done, bus.Busy}, 0);
        @(negedge clk);
        check_eq("abort.rf5", rf[5], 16'hFFFF);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule
